// File: rtl/simple_fi_array.sv
// simple_fi_array: multi-lane registered NAND/AND datapath with a timed fault-injection controller
module simple_fi_array #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] n2,
    output logic [WIDTH-1:0] q,
    input  logic             fi_start,
    input  logic             fi_abort,
    input  logic [1:0]       fi_mode,
    input  logic [WIDTH-1:0] fi_mask,
    input  logic [CNT_W-1:0] fi_delay,
    input  logic [CNT_W-1:0] fi_duration,
    output logic             fi_busy,
    output logic             fi_active,
    output logic             fi_done
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_INJECT} state_t;
    state_t             state, state_n;
    logic [WIDTH-1:0]   in1_r, in2_r, in3_r, mask_r, raw, m;
    logic [WIDTH-1:0]   pipe [STAGES];
    logic [1:0]         mode_r;
    logic [CNT_W-1:0]   cnt, cnt_n, dur_r;
    logic               done_r, done_n, ld;

    assign raw       = ~(in1_r & in2_r) & in3_r;
    assign m         = fi_active ? mask_r : '0;
    assign n2        = mode_r == 2'b01 ? raw & ~m :
                       mode_r == 2'b10 ? raw | m  :
                       mode_r == 2'b11 ? raw ^ m  : raw;
    assign q         = pipe[STAGES-1];
    assign fi_busy   = state != S_IDLE;
    assign fi_active = state == S_INJECT;
    assign fi_done   = done_r;

    // operand capture and output pipeline carrying the (possibly faulted) n2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_r <= '0;
            in2_r <= '0;
            in3_r <= '0;
            for (int s = 0; s < STAGES; s++) pipe[s] <= '0;
        end else begin
            in1_r <= in1;
            in2_r <= in2;
            in3_r <= in3;
            pipe[0] <= n2;
            for (int s = 1; s < STAGES; s++) pipe[s] <= pipe[s-1];
        end
    end

    // controller state, shared delay/duration counter and latched configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
            mode_r <= '0;
            mask_r <= '0;
            dur_r  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done_r <= done_n;
            if (ld) begin
                mode_r <= fi_mode;
                mask_r <= fi_mask;
                dur_r  <= fi_duration;
            end
        end
    end

    // next state: the counter holds the remaining delay in WAIT and remaining faulted cycles in INJECT
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        ld      = 1'b0;
        case (state)
            S_IDLE: if (fi_start && !fi_abort) begin
                ld      = 1'b1;
                state_n = fi_delay == '0 ? S_INJECT : S_WAIT;
                cnt_n   = fi_delay == '0 ? fi_duration : fi_delay;
            end
            S_WAIT: begin
                state_n = fi_abort ? S_IDLE : cnt == CNT_W'(1) ? S_INJECT : S_WAIT;
                cnt_n   = cnt == CNT_W'(1) ? dur_r : cnt - CNT_W'(1);
            end
            S_INJECT: if (fi_abort) state_n = S_IDLE;
            else if (dur_r != '0) begin
                state_n = cnt == CNT_W'(1) ? S_IDLE : S_INJECT;
                done_n  = cnt == CNT_W'(1);
                cnt_n   = cnt - CNT_W'(1);
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_simple_fi_array.sv
// tb_simple_fi_array: scoreboard bench for the fault-injection datapath (WIDTH=8, STAGES=2)
module tb_simple_fi_array;
    logic        clk = 0, rst = 1;
    logic [7:0]  in1 = 0, in2 = 0, in3 = 0, n2, q, fi_mask = 0;
    logic        fi_start = 0, fi_abort = 0, fi_busy, fi_active, fi_done;
    logic [1:0]  fi_mode = 0;
    logic [15:0] fi_delay = 0, fi_duration = 0;
    int          cyc = 0, errors = 0, checks = 0;

    typedef struct {int at; string tag; int sel; logic [7:0] val;} exp_t;
    exp_t sb[$];

    simple_fi_array #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .n2(n2), .q(q),
        .fi_start(fi_start), .fi_abort(fi_abort), .fi_mode(fi_mode), .fi_mask(fi_mask),
        .fi_delay(fi_delay), .fi_duration(fi_duration),
        .fi_busy(fi_busy), .fi_active(fi_active), .fi_done(fi_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] probe(input int sel);
        return sel == 0 ? n2 : sel == 1 ? q : sel == 2 ? {7'b0, fi_busy} :
               sel == 3 ? {7'b0, fi_active} : {7'b0, fi_done};
    endfunction

    task automatic push(input int at, input string tag, input int sel, input logic [7:0] v);
        exp_t e;
        e.at = at; e.tag = tag; e.sel = sel; e.val = v;
        sb.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk)
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].at == cyc) begin
                check(sb[i].tag, probe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end

    // stuck-at-1 on lane 0, delay 3, duration 2, on a steady F0 result; k is the sampling edge
    task automatic push_sa1(input int k, input string t);
        for (int j = 0; j < 8; j++) begin
            push(k + j, $sformatf("%s_n2_%0d", t, j), 0, (j == 3 || j == 4) ? 8'hF1 : 8'hF0);
            push(k + j, $sformatf("%s_act_%0d", t, j), 3, (j == 3 || j == 4) ? 8'h01 : 8'h00);
            push(k + j, $sformatf("%s_done_%0d", t, j), 4, j == 5 ? 8'h01 : 8'h00);
            push(k + j, $sformatf("%s_busy_%0d", t, j), 2, j < 5 ? 8'h01 : 8'h00);
            push(k + j, $sformatf("%s_q_%0d", t, j), 1, (j == 5 || j == 6) ? 8'hF1 : 8'hF0);
        end
    endtask

    task automatic start(input logic [1:0] md, input logic [7:0] mk, input int dl, input int du);
        fi_start = 1; fi_mode = md; fi_mask = mk; fi_delay = 16'(dl); fi_duration = 16'(du);
    endtask

    initial begin
        int k;
        step(3);
        check("rst_n2", n2, 8'h00);
        check("rst_q", q, 8'h00);
        check("rst_busy", {7'b0, fi_busy}, 8'h00);
        check("rst_act", {7'b0, fi_active}, 8'h00);
        check("rst_done", {7'b0, fi_done}, 8'h00);
        rst = 0;
        step();
        in1 = 8'hFF; in2 = 8'h0F; in3 = 8'hFF;
        k = cyc + 1;
        push(k, "t1_n2", 0, 8'hF0);
        push(k + 1, "t1_q_early", 1, 8'h00);
        push(k + 2, "t1_q", 1, 8'hF0);
        step(4);
        start(2'b10, 8'h01, 3, 2);
        k = cyc + 1;
        push_sa1(k, "t2");
        step(); fi_start = 0;
        step(9);
        start(2'b11, 8'hFF, 0, 1);
        k = cyc + 1;
        push(k - 1, "t3_n2_pre", 0, 8'hF0);
        push(k, "t3_n2", 0, 8'h0F);
        push(k, "t3_act", 3, 8'h01);
        push(k + 1, "t3_n2_post", 0, 8'hF0);
        push(k + 1, "t3_done", 4, 8'h01);
        push(k + 2, "t3_done_off", 4, 8'h00);
        step(); fi_start = 0;
        step(4);
        start(2'b01, 8'hF0, 0, 0);
        k = cyc + 1;
        for (int j = 0; j < 100; j += 11) push(k + j, $sformatf("t4_n2_%0d", j), 0, 8'h00);
        push(k + 99, "t4_n2_last", 0, 8'h00);
        push(k + 99, "t4_act_last", 3, 8'h01);
        push(k + 100, "t4_n2_abort", 0, 8'hF0);
        push(k + 100, "t4_act_abort", 3, 8'h00);
        push(k + 100, "t4_busy_abort", 2, 8'h00);
        push(k + 100, "t4_done0", 4, 8'h00);
        push(k + 101, "t4_done1", 4, 8'h00);
        step(); fi_start = 0;
        step(99);
        fi_abort = 1;
        step(); fi_abort = 0;
        step(4);
        start(2'b10, 8'h01, 3, 2);
        k = cyc + 1;
        push_sa1(k, "t5");
        step();
        start(2'b11, 8'hFF, 0, 5);
        step(); fi_start = 0;
        step(8);
        start(2'b11, 8'hFF, 0, 3);
        fi_abort = 1;
        k = cyc + 1;
        push(k, "t5_sa_busy", 2, 8'h00);
        push(k, "t5_sa_n2", 0, 8'hF0);
        push(k + 1, "t5_sa_busy1", 2, 8'h00);
        push(k + 1, "t5_sa_act1", 3, 8'h00);
        step(); fi_start = 0; fi_abort = 0;
        step(3);
        start(2'b10, 8'hFF, 0, 0);
        step(); fi_start = 0;
        step();
        #2;
        check("t6_pre_n2", n2, 8'hFF);
        check("t6_pre_act", {7'b0, fi_active}, 8'h01);
        rst = 1;
        #1;
        check("t6_n2", n2, 8'h00);
        check("t6_q", q, 8'h00);
        check("t6_busy", {7'b0, fi_busy}, 8'h00);
        check("t6_act", {7'b0, fi_active}, 8'h00);
        check("t6_done", {7'b0, fi_done}, 8'h00);
        step(2);
        #2 rst = 0;
        k = cyc + 1;
        for (int j = 0; j < 4; j++) begin
            push(k + j, $sformatf("t6_post_done_%0d", j), 4, 8'h00);
            push(k + j, $sformatf("t6_post_n2_%0d", j), 0, 8'hF0);
            push(k + j, $sformatf("t6_post_busy_%0d", j), 2, 8'h00);
        end
        step(8);
        foreach (sb[i]) begin
            errors++;
            $display("FAIL %s: never compared (due cyc %0d, now %0d)", sb[i].tag, sb[i].at, cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
